// File: rtl/calc_pkg.sv
// Shared definitions for the keypad digit accumulator: FSM encoding,
// digit/value limits and the width of the multiply-accumulate result.
package calc_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ENTRY = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // Intermediate width: 255*10+9 = 2559 needs 12 bits, so no wrap can hide an overflow.
  localparam int SUM_W = 12;

  localparam logic [3:0]       DIGIT_MAX = 4'd9;
  localparam logic [SUM_W-1:0] VALUE_MAX = 12'd255;

endpackage

// File: rtl/mul10_add.sv
// Combinational value*10 + digit, built from two shifts and adds.
module mul10_add
  import calc_pkg::*;
(
  input  logic [7:0]       value,
  input  logic [3:0]       digit,
  output logic [SUM_W-1:0] sum
);

  logic [SUM_W-1:0] value_ext;
  logic [SUM_W-1:0] digit_ext;

  assign value_ext = {{(SUM_W-8){1'b0}}, value};
  assign digit_ext = {{(SUM_W-4){1'b0}}, digit};

  // x*10 = x*8 + x*2
  assign sum = (value_ext << 3) + (value_ext << 1) + digit_ext;

endmodule

// File: rtl/digit_accum.sv
// Keypad decimal entry: accumulates up to MAX_DIGITS digits into an 8-bit
// operand, rejects bad keys and overflowing digits, commits on Enter.
module digit_accum
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = 3
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [3:0] In,
  input  logic       Valid,
  input  logic       Clear,
  input  logic       Enter,
  output logic [7:0] Out,
  output logic [1:0] Count,
  output logic       Done,
  output logic       Error,
  output logic       Overflow
);

  localparam logic [1:0] MAX_CNT = 2'(MAX_DIGITS);

  state_t           state, state_nxt;
  logic [7:0]       out_nxt;
  logic [1:0]       count_nxt;
  logic             done_nxt, error_nxt, overflow_nxt;
  logic [SUM_W-1:0] sum;

  mul10_add u_mul10_add (
    .value (Out),
    .digit (In),
    .sum   (sum)
  );

  // State and output registers; every output is registered.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= EMPTY;
      Out      <= '0;
      Count    <= '0;
      Done     <= 1'b0;
      Error    <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state    <= state_nxt;
      Out      <= out_nxt;
      Count    <= count_nxt;
      Done     <= done_nxt;
      Error    <= error_nxt;
      Overflow <= overflow_nxt;
    end
  end

  // Next-state logic with input priority Clear > Enter > Valid.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_nxt    = state;
    out_nxt      = Out;
    count_nxt    = Count;
    overflow_nxt = Overflow;
    done_nxt     = 1'b0;
    error_nxt    = 1'b0;

    if (Clear) begin
      state_nxt    = EMPTY;
      out_nxt      = '0;
      count_nxt    = '0;
      overflow_nxt = 1'b0;
    end else if (Enter) begin
      if (state == ENTRY) begin
        state_nxt = HOLD;
        done_nxt  = 1'b1;
      end
    end else if (Valid) begin
      if (In > DIGIT_MAX) begin
        error_nxt = 1'b1;
      end else if (state != ENTRY) begin
        // A new entry always starts fresh, even straight after a commit.
        state_nxt    = ENTRY;
        out_nxt      = {4'b0, In};
        count_nxt    = 2'd1;
        overflow_nxt = 1'b0;
      end else if (Count >= MAX_CNT) begin
        error_nxt = 1'b1;
      end else if (sum > VALUE_MAX) begin
        overflow_nxt = 1'b1;
        error_nxt    = 1'b1;
      end else begin
        out_nxt   = sum[7:0];
        count_nxt = Count + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_digit_accum.sv
// Self-checking bench for digit_accum: a behavioural reference model pushes
// the expected registered outputs when a stimulus cycle is driven, and they
// are popped and compared one edge later.
module tb_digit_accum;

  localparam int MAXD = 3;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic [3:0] In;
  logic       Valid, Clear, Enter;
  logic [7:0] Out;
  logic [1:0] Count;
  logic       Done, Error, Overflow;

  typedef struct {
    int out;
    int cnt;
    int done;
    int err;
    int ovf;
  } exp_t;

  exp_t sb[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state: 0=empty, 1=entry, 2=hold
  int m_st, m_out, m_cnt, m_ovf, m_done, m_err;

  digit_accum #(.MAX_DIGITS(MAXD)) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .In       (In),
    .Valid    (Valid),
    .Clear    (Clear),
    .Enter    (Enter),
    .Out      (Out),
    .Count    (Count),
    .Done     (Done),
    .Error    (Error),
    .Overflow (Overflow)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input int got, input int exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_out = 0; m_cnt = 0; m_ovf = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_step(input bit v, input int d, input bit c, input bit e);
    int acc;
    m_done = 0;
    m_err  = 0;
    if (c) begin
      m_st = 0; m_out = 0; m_cnt = 0; m_ovf = 0;
    end else if (e) begin
      if (m_st == 1) begin
        m_st = 2;
        m_done = 1;
      end
    end else if (v) begin
      acc = m_out * 10 + d;
      if (d > 9)                    m_err = 1;
      else if (m_st != 1) begin
        m_st = 1; m_out = d; m_cnt = 1; m_ovf = 0;
      end
      else if (m_cnt >= MAXD)       m_err = 1;
      else if (acc > 255) begin
        m_ovf = 1; m_err = 1;
      end else begin
        m_out = acc; m_cnt = m_cnt + 1;
      end
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge.
  task automatic step(input string tag, input bit v, input int d, input bit c, input bit e);
    exp_t x;
    @(negedge Clk);
    Valid = v; In = 4'(d); Clear = c; Enter = e;
    model_step(v, d, c, e);
    x.out = m_out; x.cnt = m_cnt; x.done = m_done; x.err = m_err; x.ovf = m_ovf;
    sb.push_back(x);
    @(posedge Clk);
    #1;
    Valid = 1'b0; Clear = 1'b0; Enter = 1'b0;
    if (sb.size() == 0) begin
      check({tag, ".sb_empty"}, 1, 0);
    end else begin
      x = sb.pop_front();
      check({tag, ".out"},   int'(Out),      x.out);
      check({tag, ".count"}, int'(Count),    x.cnt);
      check({tag, ".done"},  int'(Done),     x.done);
      check({tag, ".error"}, int'(Error),    x.err);
      check({tag, ".ovf"},   int'(Overflow), x.ovf);
      check({tag, ".excl"},  int'(Done & Error), 0);
    end
  endtask

  task automatic key(input string tag, input int d);
    step(tag, 1'b1, d, 1'b0, 1'b0);
  endtask

  initial begin
    Reset_n = 1'b0; In = '0; Valid = 1'b0; Clear = 1'b0; Enter = 1'b0;
    model_reset();
    #12;
    check("rst.out",   int'(Out),      0);
    check("rst.count", int'(Count),    0);
    check("rst.done",  int'(Done),     0);
    check("rst.error", int'(Error),    0);
    check("rst.ovf",   int'(Overflow), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // 2,5,5 then Enter -> 255, three digits, single Done pulse
    key("max.k2", 2);
    key("max.k5a", 5);
    key("max.k5b", 5);
    step("max.enter", 1'b0, 0, 1'b0, 1'b1);
    check("max.out255", int'(Out), 255);
    check("max.cnt3",   int'(Count), 3);
    check("max.done1",  int'(Done), 1);
    step("max.idle", 1'b0, 0, 1'b0, 1'b0);
    check("max.done_once", int'(Done), 0);
    step("hold.enter", 1'b0, 0, 1'b0, 1'b1);
    check("hold.no_done", int'(Done), 0);

    // From HOLD a digit starts a fresh entry: 2,5 then 6 overflows
    key("ovf.k2", 2);
    check("fresh.out", int'(Out), 2);
    check("fresh.cnt", int'(Count), 1);
    key("ovf.k5", 5);
    key("ovf.k6", 6);
    check("ovf.err",  int'(Error), 1);
    check("ovf.flag", int'(Overflow), 1);
    check("ovf.out",  int'(Out), 25);
    check("ovf.cnt",  int'(Count), 2);
    step("ovf.idle", 1'b0, 0, 1'b0, 1'b0);
    check("ovf.sticky", int'(Overflow), 1);

    // Invalid key in EMPTY
    step("bad.clear", 1'b0, 0, 1'b1, 1'b0);
    key("bad.kC", 12);
    check("bad.err", int'(Error), 1);
    check("bad.out", int'(Out), 0);
    step("bad.enter", 1'b0, 0, 1'b0, 1'b1);
    check("bad.still_empty", int'(Done), 0);

    // Digit limit: 1,2,3 then 4 rejected
    key("lim.k1", 1);
    key("lim.k2", 2);
    key("lim.k3", 3);
    key("lim.k4", 4);
    check("lim.err", int'(Error), 1);
    check("lim.out", int'(Out), 123);
    key("lim.kF", 15);
    check("lim.bad_keeps", int'(Out), 123);

    // Clear + Enter + Valid together during ENTRY: Clear wins
    step("pri.all", 1'b1, 7, 1'b1, 1'b1);
    check("pri.out",  int'(Out), 0);
    check("pri.cnt",  int'(Count), 0);
    check("pri.done", int'(Done), 0);

    // Enter + Valid together: Enter wins
    key("pri2.k8", 8);
    step("pri2.ev", 1'b1, 3, 1'b0, 1'b1);
    check("pri2.out", int'(Out), 8);

    // Mid-entry asynchronous reset
    key("arst.k4", 4);
    key("arst.k2", 2);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    check("arst.out",   int'(Out),   0);
    check("arst.count", int'(Count), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    key("arst.k9", 9);
    check("arst.out9", int'(Out), 9);
    check("arst.cnt1", int'(Count), 1);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      bit v, c, e;
      int d;
      c = ($urandom_range(0, 15) == 0);
      e = ($urandom_range(0, 7) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 4) == 0) ? $urandom_range(10, 15) : $urandom_range(0, 9);
      step("rnd", v, d, c, e);
    end

    check("sb.drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got stuck expected finish");
    $fatal(1);
  end

endmodule

// File: doc/digit_accum.md
DIGIT_ACCUM -- requirements
Module: digit_accum

Interface
REQ-001 SHALL have parameter MAX_DIGITS, default 3, setting the maximum decimal digits per operand (range 1..3).
REQ-002 SHALL have port Clk, input, 1, the single clock; all state changes on the rising edge.
REQ-003 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port In, input, 4, the keypad digit code (binary 0..15).
REQ-005 SHALL have port Valid, input, 1, In carries a keypress this cycle.
REQ-006 SHALL have port Clear, input, 1, discards the current entry.
REQ-007 SHALL have port Enter, input, 1, commits the current entry.
REQ-008 SHALL have port Out, output, 8, the accumulated binary operand.
REQ-009 SHALL have port Count, output, 2, the number of digits accepted in the current entry.
REQ-010 SHALL have port Done, output, 1, a one-cycle pulse when an operand is committed.
REQ-011 SHALL have port Error, output, 1, a one-cycle pulse when a keypress is rejected.
REQ-012 SHALL have port Overflow, output, 1, sticky flag set when the entry exceeded 255.

Function
REQ-013 SHALL implement states EMPTY, ENTRY and HOLD.
REQ-014 SHALL register all outputs; a qualified input on edge N SHALL be visible on the outputs after edge N.
REQ-015 SHALL apply input priority Clear > Enter > Valid when several are asserted in one cycle.
REQ-016 On Clear in any state, SHALL go to EMPTY with Out=0, Count=0 and Overflow=0, and SHALL NOT pulse Done or Error.
REQ-017 On Valid with In <= 9 in EMPTY or HOLD, SHALL set Out=In, Count=1 and Overflow=0, and go to ENTRY; an entry SHALL therefore start fresh after HOLD.
REQ-018 On Valid with In <= 9 in ENTRY and Count < MAX_DIGITS, SHALL compute Out*10+In at 12-bit width.
REQ-019 If that result is <= 255, SHALL load it into Out and increment Count.
REQ-020 If that result is > 255, SHALL leave Out and Count unchanged, set Overflow and pulse Error.
REQ-021 On Valid in ENTRY with Count == MAX_DIGITS, SHALL leave Out and Count unchanged and pulse Error.
REQ-022 On Valid with In >= 10 in any state, SHALL reject the keypress, pulse Error and leave all state unchanged.
REQ-023 On Enter in ENTRY, SHALL go to HOLD, pulse Done, and hold Out and Count stable.
REQ-024 On Enter in EMPTY or HOLD, SHALL take no action and SHALL NOT pulse Done.
REQ-025 SHALL keep Overflow asserted until Clear, reset, or the start of a new entry.
REQ-026 Done and Error SHALL never be asserted in the same cycle.
REQ-027 With no qualified input, all registers SHALL hold their values.
REQ-028 SHALL implement the multiply by 10 as (v<<3)+(v<<1), with no hardware multiplier.

Reset
REQ-029 While Reset_n=0, SHALL force state=EMPTY, Out=0, Count=0, Done=0, Error=0 and Overflow=0, asynchronously.
REQ-030 Reset asserted mid-entry SHALL discard the partial operand; the first Valid after reset release SHALL be handled as in EMPTY.

Structure
REQ-031 The state encoding, the constants DIGIT_MAX=9 and VALUE_MAX=255, and the 12-bit intermediate width SHALL live in shared package calc_pkg.
REQ-032 The multiply-by-10-plus-digit datapath SHALL be a combinational sub-module named mul10_add (inputs 8-bit value and 4-bit digit, output 12-bit sum).
REQ-033 The block SHALL be sequential logic with one clock domain, roughly 120-400 lines of RTL.

Verification
REQ-034 Bench SHALL apply reset, then Valid with In=2, 5, 5 and then Enter, and check Out=8'd255, Count=3 and one Done pulse on the edge after Enter.
REQ-035 Bench SHALL enter 2, 5, then 6, and check Error pulses, Overflow=1, Out stays 25 and Count stays 2.
REQ-036 Bench SHALL apply Valid with In=4'hC in EMPTY and check Error pulses, state stays EMPTY and Out=0.
REQ-037 Bench SHALL enter 1, 2, 3 and then 4 with MAX_DIGITS=3, and check Error on the fourth key and Out=123.
REQ-038 Bench SHALL assert Clear, Enter and Valid (In=7) in the same cycle during ENTRY, and check Out=0, Count=0 and no Done.
REQ-039 Bench SHALL enter 4, 2, drop Reset_n mid-cycle, then release it and press 9, and check Out=0 immediately on reset, then Out=9 and Count=1.
